// File: rtl/gpio_bank.sv
// Multi-channel GPIO bank: synchronised inputs, registered outputs, sticky edge status and a
// level interrupt. Define GPIO_BOTH_EDGE_EN to latch falling as well as rising input edges.
module gpio_bank #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(NCH) + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AW-1:0]        a,
  input  logic [WIDTH-1:0]     wd,
  output logic [WIDTH-1:0]     rd,
  input  logic [NCH*WIDTH-1:0] gpI,
  output logic [NCH*WIDTH-1:0] gpO,
  output logic                 irq
);

  localparam logic [1:0] ARM_DONE = 2'd2;

  logic [NCH-1:0][WIDTH-1:0] s1_q, in_q, prev_q, prev_d;
  logic [NCH-1:0][WIDTH-1:0] out_q, out_d, ie_q, ie_d, is_q, is_d, edg;
  logic [1:0]                arm_q;
  logic                      armed;
  logic [31:0]               chan;

  generate
    if (NCH > 1) begin : g_chan
      assign chan = 32'(a[AW-1:2]);
    end else begin : g_chan_single
      assign chan = '0;
    end
  endgenerate

  assign armed = (arm_q == ARM_DONE);

  always_comb begin
    prev_d = prev_q;
    out_d  = out_q;
    ie_d   = ie_q;
    is_d   = is_q;
    edg    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (armed) begin
`ifdef GPIO_BOTH_EDGE_EN
        edg[c] = in_q[c] ^ prev_q[c];
`else
        edg[c] = in_q[c] & ~prev_q[c];
`endif
      end
      // While the synchronisers fill, prev tracks the value IN is about to take so that
      // levels present at reset release are not mistaken for edges.
      prev_d[c] = armed ? in_q[c] : s1_q[c];
      if (we && (chan == 32'(c)) && (a[1:0] == 2'd1)) out_d[c] = wd;
      if (we && (chan == 32'(c)) && (a[1:0] == 2'd2)) ie_d[c] = wd;
      if (we && (chan == 32'(c)) && (a[1:0] == 2'd3)) begin
        is_d[c] = (is_q[c] & ~wd) | edg[c];
      end else begin
        is_d[c] = is_q[c] | edg[c];
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int c = 0; c < NCH; c++) begin
      if (chan == 32'(c)) begin
        case (a[1:0])
          2'd0:    rd = in_q[c];
          2'd1:    rd = out_q[c];
          2'd2:    rd = ie_q[c];
          default: rd = is_q[c];
        endcase
      end
    end
  end

  always_comb begin
    irq = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      irq = irq | (|(is_q[c] & ie_q[c]));
    end
  end

  assign gpO = out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      in_q   <= '0;
      prev_q <= '0;
      out_q  <= '0;
      ie_q   <= '0;
      is_q   <= '0;
      arm_q  <= '0;
    end else begin
      s1_q   <= gpI;
      in_q   <= s1_q;
      prev_q <= prev_d;
      out_q  <= out_d;
      ie_q   <= ie_d;
      is_q   <= is_d;
      if (!armed) arm_q <= arm_q + 2'd1;
    end
  end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter NCH, default 2, is the number of GPIO channels, legal range 1..8.
REQ-002 Parameter WIDTH, default 32, is the bits per channel, legal range 1..32.
REQ-003 Localparam AW = clog2(NCH)+2 is the word-address width; NCH=1 gives AW=2.
REQ-004 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  Asynchronous, active-low reset.
REQ-006 we  input  1  Write strobe, sampled on the rising edge of clk.
REQ-007 a  input  AW  Word address; a[1:0] selects the register, upper bits select the channel.
REQ-008 wd  input  WIDTH  Write data.
REQ-009 rd  output  WIDTH  Combinational read data for address a.
REQ-010 gpI  input  NCH*WIDTH  Asynchronous inputs; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-011 gpO  output  NCH*WIDTH  Registered outputs, packed the same way as gpI.
REQ-012 irq  output  1  Level interrupt, equal to the OR over all channels of (IS & IE).

Function
REQ-013 Per-channel register map:
- a[1:0]=0 IN: read-only; the synchronised input value.
- a[1:0]=1 OUT: read/write; drives gpO.
- a[1:0]=2 IE: read/write; interrupt enable mask.
- a[1:0]=3 IS: read / write-1-to-clear; sticky edge status.
REQ-014 A channel index >= NCH SHALL read as 0, and writes to it SHALL be ignored.
REQ-015 Writes to IN SHALL be ignored.
REQ-016 Each gpI bit SHALL pass through a two-flop synchroniser; IN reflects a change of gpI two clk edges after it is applied.
REQ-017 A prev register SHALL hold the last IN value; an edge is detected when IN differs from prev in the direction selected by REQ-026.
REQ-018 A detected edge SHALL set the matching IS bit on the same clk edge that updates prev (third edge after the gpI change), regardless of IE.
REQ-019 A write of wd to IS SHALL clear every bit where wd=1 and leave bits where wd=0 unchanged.
REQ-020 When an edge and a W1C clear hit the same IS bit in the same cycle, the set SHALL win and the bit stays 1.
REQ-021 A write to OUT or IE SHALL take effect on the clk edge where we=1; gpO changes on that same edge.
REQ-022 irq SHALL be combinational from the IS and IE registers; it is not delayed by an extra cycle.
REQ-023 A 2-bit arm counter SHALL count from 0 to 2 after reset release, then saturate.
REQ-024 Edge detection SHALL stay disabled until the arm counter reaches 2, so no IS bits are set while the synchronisers fill.

Reset
REQ-025 While reset=0, the following SHALL be asynchronously forced to 0:
- synchroniser flops, IN, prev, OUT, IE, IS, arm counter;
- therefore gpO=0 and irq=0.
rd is then 0 except in the IN/OUT/IE/IS fields, which all read 0 anyway.
Asserting reset mid-operation SHALL discard pending edges and sticky status; status set before the reset does not survive it.

Configuration
REQ-026 Macro GPIO_BOTH_EDGE_EN selects the edge polarity:
- defined: both rising and falling edges of IN set IS;
- undefined: only rising edges (prev=0, IN=1) set IS; falling edges are ignored.
All other behaviour is identical in both builds.

Verification
REQ-027 Channel 1, reset sequence with gpI high:
- stimulus: NCH=2; hold gpI channel-1 bits =32'h0000_00FF through reset; release reset; run 5 cycles.
- required response: IS1 stays 0 and irq=0.
REQ-028 Channel 0 rising edge and IN latency:
- stimulus: write IE0=32'h1; raise gpI bit0 at cycle k.
- required response: IN0=1 readable at k+2; IS0=32'h1 and irq=1 at k+3.
REQ-029 Channel 0 W1C clear:
- stimulus: after REQ-028, write IS0=32'h1.
- required response: IS0=0 and irq=0 on the next edge.
- stimulus: repeat, with a new bit0 edge landing in the same cycle as the W1C.
- required response: IS0 stays 32'h1 (set wins).
REQ-030 Channel 1 OUT write and out-of-range access:
- stimulus: write OUT1=32'hA5A5_0F0F.
- required response: gpO[63:32]=32'hA5A5_0F0F on the write edge; gpO[31:0] unchanged.
- stimulus: with NCH=2, AW=3, so a is 3 bits and no out-of-range channel index exists; use NCH=3 (AW=4) and write/read channel 3.
- required response: the write is ignored and the read returns 0.
REQ-031 Channel 0 falling edge, per build:
- stimulus: falling edge on gpI bit3.
- required response with GPIO_BOTH_EDGE_EN: IS0 bit3=1.
- required response without it: IS0 stays 0.
REQ-032 Reset mid-operation:
- stimulus: set OUT0=32'hFFFF_FFFF, IE0=32'hF and IS0 bits, then pulse reset low for 1 ns between clock edges.
- required response: gpO=0, irq=0 and all registers read 0 immediately.
